// File: rtl/screen_scanner_if.sv
// rtl/screen_scanner_if.sv - screen RAM read port and display output bundle
interface screen_scanner_if;
    logic [11:0] address;
    logic [15:0] data;
    logic        pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output address,
        input  data,
        output pixel,
        output de,
        output hsync,
        output vsync,
        output frame_start
    );

    modport slave (
        input  address,
        output data,
        input  pixel,
        input  de,
        input  hsync,
        input  vsync,
        input  frame_start
    );
endinterface

// File: rtl/screen_scanner.sv
// rtl/screen_scanner.sv - screen RAM scan, pixel serializer and display timing
module screen_scanner #(
    parameter int H_ACTIVE        = 320,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 32,
    parameter int H_BP            = 32,
    parameter int V_ACTIVE        = 192,
    parameter int V_FP            = 4,
    parameter int V_SYNC          = 4,
    parameter int V_BP            = 20,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_ce,
    screen_scanner_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0]  V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0]  V_ACT      = 9'(V_ACTIVE);
    localparam logic [8:0]  V_ACT_LAST = 9'(V_ACTIVE - 1);
    localparam logic [8:0]  VS_BEG     = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0]  VS_END     = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] ROW_STEP   = 12'(H_ACTIVE / 16);
    localparam logic        SYNC_OFF   = (SYNC_ACTIVE_LOW != 0);
    localparam logic        SYNC_ON    = ~SYNC_OFF;

    logic [9:0]  h;
    logic [8:0]  v;
    logic [11:0] row_base;
    logic [14:0] shift;
    logic        active;
    logic        pixel_q;
    logic        de_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_start_q;

    assign active = (h < H_ACT) && (v < V_ACT);

    // Outside the active window the address parks at 0 so it never runs past the RAM.
    assign bus.address     = active ? (row_base + {7'd0, h[8:4]}) : 12'd0;
    assign bus.pixel       = pixel_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h             <= '0;
            v             <= '0;
            row_base      <= '0;
            shift         <= '0;
            pixel_q       <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (pix_ce) begin
                if (h == H_LAST) begin
                    h <= '0;
                    if (v == V_LAST) begin
                        v             <= '0;
                        row_base      <= '0;
                        frame_start_q <= 1'b1;
                    end else begin
                        v <= v + 9'd1;
                        // Row base stops at the last active line; it is not used again until wrap.
                        if (v < V_ACT_LAST) begin
                            row_base <= row_base + ROW_STEP;
                        end
                    end
                end else begin
                    h <= h + 10'd1;
                end

                de_q    <= active;
                hsync_q <= ((h >= HS_BEG) && (h < HS_END)) ? SYNC_ON : SYNC_OFF;
                vsync_q <= ((v >= VS_BEG) && (v < VS_END)) ? SYNC_ON : SYNC_OFF;

                if (active) begin
                    if (h[3:0] == 4'd0) begin
                        pixel_q <= bus.data[0];
                        shift   <= bus.data[15:1];
                    end else begin
                        pixel_q <= shift[0];
                        shift   <= {1'b0, shift[14:1]};
                    end
                end else begin
                    pixel_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/screen_scanner.md
Name: screen_scanner

Overview:
- Read-side engine for the 3840-word screen RAM: generates RAM addresses and serializes each 16-bit word into a 1-bit pixel stream.
- Produces display timing (de, hsync, vsync) for a 320x192 monochrome panel: 20 words per line, 192 lines, 3840 words.
- Sits between the screen RAM read port (combinational, same-cycle data) and the display PHY. The CPU keeps the write port.

Parameters:
- H_ACTIVE, 320: visible pixels per line; must be a multiple of 16.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 32: hsync width, in pixels.
- H_BP, 32: horizontal back porch, in pixels. Line total = 400.
- V_ACTIVE, 192: visible lines.
- V_FP, 4: vertical front porch, in lines.
- V_SYNC, 4: vsync width, in lines.
- V_BP, 20: vertical back porch, in lines. Frame total = 220.
- SYNC_ACTIVE_LOW, 1: 1 means hsync and vsync are driven low while asserted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable; one pixel position per clk edge with pix_ce=1
- address  out  12  screen RAM read address (combinational)
- data  in  16  screen RAM read data for address (same cycle)
- pixel  out  1  current pixel; 1 = black
- de  out  1  display enable (active region)
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Counters
  - h (0..399) and v (0..219) hold the position of the next pixel to emit.
  - They change only on clk edges with pix_ce=1.
  - h wraps 399->0. v increments when h wraps and itself wraps 219->0.
- Address
  - address = v*20 + h[8:4] when h<320 and v<192; otherwise 0.
  - Implement with a row-base register (+20 per active line, cleared at frame wrap). No multiplier.
  - Max active address is 3839; an address >= 3840 must never be driven.
- Output update
  - On an edge with pix_ce=1, all outputs are registered from the pre-edge (h,v). Outputs therefore lag the counters by one pix_ce.
  - de <= (h<320 && v<192).
  - hsync is asserted for 336<=h<368. vsync is asserted for 196<=v<200. Polarity follows SYNC_ACTIVE_LOW.
- Serializer
  - Active and h%16==0: pixel <= data[0]; shift <= data[15:1].
  - Active otherwise: pixel <= shift[0]; shift <= shift>>1.
  - Bit 0 is the leftmost pixel of each word.
  - Inactive: pixel <= 0.
- frame_start
  - Asserted for exactly one clk, on the pix_ce edge where (h,v) advances from (399,219) to (0,0).
  - Deasserted on every other edge, including edges with pix_ce=0.
- pix_ce=0: all state and registered outputs hold, except frame_start, which clears.
- Data capture: data is sampled only on word-boundary edges. RAM writes landing mid-word affect the next frame only.
- Reset
  - Values while rst_n=0: h=v=0, shift=0, pixel=0, de=0, hsync and vsync deasserted, frame_start=0.
  - Reset mid-frame abandons the frame; the scan restarts at (0,0) after release.
  - No frame_start pulse is generated by reset itself.

Test Plan:
- Reset, then pix_ce=1 every clk with an all-zero RAM model:
  - First 320 pixel clocks of line 0: de=1 and pixel=0.
  - de falls after 320 pixels.
  - hsync is low for exactly 32 pixels, starting 16 pixels after de falls.
  - Line period is 400 pixels.
- RAM word 0 = 0x0001, word 1 = 0x8000: pixel sequence on line 0 is 1, then 30 zeros, then 1 (pixels 0 and 31).
- Word 3839 = 0xFFFF:
  - address reaches 3839 at v=191, h=304..319, and last-line pixels 304..319 = 1.
  - address never exceeds 3839 across two full frames.
- Free-running pix_ce:
  - vsync is low for lines 196..199.
  - frame_start pulses once every 88000 pix_ce edges (400x220), one clk wide.
- pix_ce asserted every 4th clk: outputs identical to the 1:1 run when sampled per pix_ce, and held between enables.
- rst_n pulsed low at v=100, h=150 (asynchronously, mid-cycle):
  - Outputs go to reset values immediately.
  - After release, the first pixel comes from address 0 and the next frame_start is exactly 88000 pix_ce edges later.
